// File: rtl/step_scheduler.sv
// step_scheduler: play-mode step sequencer and trigger scheduler.
// Walks an 8-step pattern at a programmable step period. Each step's 4-bit
// sample pattern is gated for the first gate_lim ticks of the step, and the
// live pads are ORed in. Every output is registered on hz2m.
//
// Optional feature: define STEP_SCHED_SWING_EN to add the swing port. With it,
// odd steps last swing extra ticks.
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | not playing; tick/step held at 0, play_smpl = raw
// RUN   | stepping through the pattern
module step_scheduler #(
   parameter int STEPS = 8,
   parameter int CW    = 20
) (
   input  logic          hz2m,
   input  logic          reset,
   input  logic          run,
   input  logic [CW-1:0] tempo_lim,
   input  logic [CW-1:0] gate_lim,
   input  logic [31:0]   pattern,
   input  logic [3:0]    raw,
`ifdef STEP_SCHED_SWING_EN
   input  logic [CW-1:0] swing,
`endif
   output logic [2:0]    step_idx,
   output logic [7:0]    step_onehot,
   output logic [3:0]    play_smpl,
   output logic          beat,
   output logic          running
);

   typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

   localparam logic [2:0] LAST_STEP = 3'(STEPS - 1);

   state_t        state, state_nxt;
   logic [CW-1:0] tick, tick_nxt;
   logic [2:0]    step_nxt;
   logic [7:0]    onehot_nxt;
   logic [3:0]    play_nxt;
   logic [3:0]    gated;
   logic          beat_nxt;
   logic          running_nxt;
   logic          step_end;

`ifdef STEP_SCHED_SWING_EN
   // Odd steps stretch by swing; the sum is one bit wider so it never wraps.
   logic [CW:0] period;
   assign period   = {1'b0, tempo_lim} + (step_idx[0] ? {1'b0, swing} : '0);
   assign step_end = ({1'b0, tick} >= period);
`else
   // >= rather than == so that lowering tempo_lim mid-step ends the step at once.
   assign step_end = (tick >= tempo_lim);
`endif

   // Pattern bits for the current step, passed only inside the gate window.
   assign gated = (tick < gate_lim) ? pattern[{step_idx, 2'b00} +: 4] : 4'b0000;

   // State register.
   always_ff @(posedge hz2m or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state, counters and output values. Pattern triggers are passed only
   // while RUN continues through the edge, so that dropping run yields raw alone.
   always_comb begin
      state_nxt = run ? S_RUN : S_IDLE;
      tick_nxt  = '0;
      step_nxt  = '0;
      beat_nxt  = 1'b0;
      play_nxt  = raw;
      if (state == S_RUN && run) begin
         play_nxt = gated | raw;
         if (step_end) begin
            step_nxt = (step_idx == LAST_STEP) ? 3'd0 : step_idx + 3'd1;
            beat_nxt = 1'b1;
         end else begin
            tick_nxt = tick + CW'(1);
            step_nxt = step_idx;
         end
      end else if (state == S_IDLE && run) begin
         beat_nxt = 1'b1;
      end
      running_nxt = (state_nxt == S_RUN);
      onehot_nxt  = running_nxt ? (8'b1 << step_nxt) : 8'b0;
   end

   // Counter and output registers.
   always_ff @(posedge hz2m or posedge reset) begin
      if (reset) begin
         tick        <= '0;
         step_idx    <= '0;
         step_onehot <= '0;
         play_smpl   <= '0;
         beat        <= 1'b0;
         running     <= 1'b0;
      end else begin
         tick        <= tick_nxt;
         step_idx    <= step_nxt;
         step_onehot <= onehot_nxt;
         play_smpl   <= play_nxt;
         beat        <= beat_nxt;
         running     <= running_nxt;
      end
   end

endmodule

// File: tb/tb_step_scheduler.sv
// tb_step_scheduler: directed test of step_scheduler with hand-computed expectations.
module tb_step_scheduler;

   localparam int CW = 20;

   logic          hz2m = 1'b0;
   logic          reset;
   logic          run;
   logic [CW-1:0] tempo_lim;
   logic [CW-1:0] gate_lim;
   logic [31:0]   pattern;
   logic [3:0]    raw;
   logic [CW-1:0] swing;
   logic [2:0]    step_idx;
   logic [7:0]    step_onehot;
   logic [3:0]    play_smpl;
   logic          beat;
   logic          running;

   int total = 0;
   int bad   = 0;

   step_scheduler #(.STEPS(8), .CW(CW)) dut (
      .hz2m        (hz2m),
      .reset       (reset),
      .run         (run),
      .tempo_lim   (tempo_lim),
      .gate_lim    (gate_lim),
      .pattern     (pattern),
      .raw         (raw),
`ifdef STEP_SCHED_SWING_EN
      .swing       (swing),
`endif
      .step_idx    (step_idx),
      .step_onehot (step_onehot),
      .play_smpl   (play_smpl),
      .beat        (beat),
      .running     (running)
   );

   always #5 hz2m = ~hz2m;

   task automatic clk1();
      @(posedge hz2m);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [3:0] exp_play;
      int t, s, ns;

      reset = 1'b1; run = 1'b1; tempo_lim = 3; gate_lim = 2;
      pattern = 32'h8000_0001; raw = 4'b0000; swing = '0;

      // Reset held with run high: everything stays 0.
      clk1(); clk1();
      chk("rst_step",    32'(step_idx),    0);
      chk("rst_onehot",  32'(step_onehot), 0);
      chk("rst_play",    32'(play_smpl),   0);
      chk("rst_beat",    32'(beat),        0);
      chk("rst_running", 32'(running),     0);

      // First edge after release starts step 0.
      reset = 1'b0;
      clk1();
      chk("start_running", 32'(running),     1);
      chk("start_step",    32'(step_idx),    0);
      chk("start_beat",    32'(beat),        1);
      chk("start_onehot",  32'(step_onehot), 32'h01);
      chk("start_play",    32'(play_smpl),   0);

      // Full pattern pass with wrap: 4-cycle steps, 2-tick gate on steps 0 and 7.
      for (int c = 1; c <= 33; c++) begin
         clk1();
         t  = (c - 1) % 4;
         s  = ((c - 1) / 4) % 8;
         ns = (c / 4) % 8;
         exp_play = 4'b0000;
         if (t < 2 && s == 0) exp_play = 4'b0001;
         if (t < 2 && s == 7) exp_play = 4'b1000;
         chk($sformatf("walk_step_c%0d", c),   32'(step_idx),    32'(ns));
         chk($sformatf("walk_beat_c%0d", c),   32'(beat),        32'(c % 4 == 0));
         chk($sformatf("walk_onehot_c%0d", c), 32'(step_onehot), 32'(1) << ns);
         chk($sformatf("walk_play_c%0d", c),   32'(play_smpl),   32'(exp_play));
      end

      // Raw pads in RUN with an empty pattern.
      pattern = 32'h0; raw = 4'b0100;
      clk1();
      chk("raw_run_on", 32'(play_smpl), 32'h4);
      raw = 4'b0000;
      clk1();
      chk("raw_run_off", 32'(play_smpl), 0);

      // Stop, then raw pads in IDLE.
      run = 1'b0;
      clk1();
      chk("stop_running", 32'(running),     0);
      chk("stop_onehot",  32'(step_onehot), 0);
      chk("stop_step",    32'(step_idx),    0);
      raw = 4'b0100;
      clk1();
      chk("raw_idle_on", 32'(play_smpl), 32'h4);
      raw = 4'b0000;

      // Whole-step gate, all triggers set; drop run at step 5 tick 2.
      pattern = 32'hFFFF_FFFF; gate_lim = 4; run = 1'b1;
      clk1();
      chk("run2_beat", 32'(beat),      1);
      chk("run2_play", 32'(play_smpl), 0);
      repeat (22) clk1();
      chk("mid_step5", 32'(step_idx),  5);
      chk("mid_play",  32'(play_smpl), 32'hF);
      run = 1'b0;
      clk1();
      chk("drop_running", 32'(running),     0);
      chk("drop_onehot",  32'(step_onehot), 0);
      chk("drop_step",    32'(step_idx),    0);
      chk("drop_beat",    32'(beat),        0);
      chk("drop_play",    32'(play_smpl),   0);
      clk1(); clk1();
      run = 1'b1;
      clk1();
      chk("restart_step",   32'(step_idx),    0);
      chk("restart_beat",   32'(beat),        1);
      chk("restart_onehot", 32'(step_onehot), 32'h01);
      chk("restart_play",   32'(play_smpl),   0);
      clk1();
      chk("restart_play2", 32'(play_smpl), 32'hF);
      chk("restart_beat2", 32'(beat),      0);

      // Tempo drop 9 -> 2 at tick 6.
      run = 1'b0;
      clk1();
      run = 1'b1; tempo_lim = 9;
      clk1();
      repeat (6) clk1();
      chk("tempo_pre_step", 32'(step_idx), 0);
      tempo_lim = 2;
      clk1();
      chk("tempo_cut_beat", 32'(beat),     1);
      chk("tempo_cut_step", 32'(step_idx), 1);
      clk1();
      chk("tempo_b1", 32'(beat), 0);
      clk1();
      chk("tempo_b2", 32'(beat), 0);
      clk1();
      chk("tempo_b3", 32'(beat),     1);
      chk("tempo_s3", 32'(step_idx), 2);

      // Asynchronous reset mid-step.
      clk1();
      reset = 1'b1;
      #1;
      chk("arst_step",    32'(step_idx),    0);
      chk("arst_running", 32'(running),     0);
      chk("arst_onehot",  32'(step_onehot), 0);
      chk("arst_play",    32'(play_smpl),   0);
      clk1();
      reset = 1'b0;
      clk1();
      chk("arst_restart_step", 32'(step_idx), 0);
      chk("arst_restart_beat", 32'(beat),     1);

`ifdef STEP_SCHED_SWING_EN
      // Swing: steps alternate 4 and 6 cycles.
      tempo_lim = 3; swing = 2; run = 1'b0;
      clk1();
      run = 1'b1;
      clk1();
      for (int k = 1; k <= 20; k++) begin
         clk1();
         chk($sformatf("swing_beat_k%0d", k), 32'(beat),
             32'(k == 4 || k == 10 || k == 14 || k == 20));
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/step_scheduler.md
# step_scheduler

Play-mode step sequencer and trigger scheduler for the drum machine. It walks an 8-step pattern at a programmable step period and gates each step's 4-bit sample pattern for a programmable number of ticks. It ORs in the live raw pads and drives the registered sample-enable vector consumed by the four sample players. It replaces the free-running BPM divider, play sequencer and drift-correcting enable counter with one synchronously coherent block on the 2 MHz clock.

## Interface
Parameters:
- `STEPS`, default 8: number of steps. Fixed at 8; `step_idx` is 3 bits wide.
- `CW`, default 20: width of the tick counter and of the period/gate limits.

Ports:
- `hz2m`  in  1  system clock, 2 MHz.
- `reset`  in  1  asynchronous, active-high reset.
- `run`  in  1  level; high while the controller is in PLAY mode.
- `tempo_lim`  in  CW  step period minus 1, in `hz2m` ticks. 499999 gives 4 steps/s.
- `gate_lim`  in  CW  number of ticks at the start of each step during which pattern triggers are passed.
- `pattern`  in  32  step i sample bits at `[4i+3:4i]`. Bit order is {kick, clap, hihat, snare}.
- `raw`  in  4  live pad sample enables, same bit order.
- `swing`  in  CW  extra ticks added to odd steps. Present only with `STEP_SCHED_SWING_EN`.
- `step_idx`  out  3  current step.
- `step_onehot`  out  8  `1 << step_idx` while running, 0 in IDLE.
- `play_smpl`  out  4  sample enables to the sample players.
- `beat`  out  1  one-cycle pulse on the first tick of each step.
- `running`  out  1  high in RUN.

## Operation
- States:
  - IDLE: counters held at 0.
  - RUN: stepping.
- Transitions:
  - IDLE→RUN when `run`=1 is sampled.
  - RUN→IDLE when `run`=0 is sampled.
  - No other states.
- Tick counter `tick` (CW bits) behaviour in RUN, evaluated each `hz2m` edge:
  - If `tick >= period`: `tick`←0 and `step_idx`←`step_idx`+1, wrapping 7→0.
  - Otherwise: `tick`←`tick`+1.
- `period` = `tempo_lim`, except for odd steps under `STEP_SCHED_SWING_EN` (see Configuration).
- Because the compare is `>=`, lowering `tempo_lim` below the current `tick` ends the step on the next edge. There is no wrap through 2^CW.
- Entering RUN: `tick`=0, `step_idx`=0.
- Leaving RUN: `tick` and `step_idx` clear to 0 on the same edge.
- `beat` is registered. It is 1 in the cycle after an edge that sets `tick` to 0 while in RUN, including the IDLE→RUN edge.
- `play_smpl` is registered. Each edge it loads one of:
  - RUN: `((tick < gate_lim) ? pattern[4*step_idx+:4] : 4'b0) | raw`, computed from pre-edge `tick` and `step_idx`.
  - IDLE: `raw`.
- Gate edge cases:
  - `gate_lim`=0 blocks all pattern triggers.
  - `gate_lim` > period gates the whole step. Consecutive active steps then hold the enable continuously and do not retrigger; this is accepted.
- `step_onehot` and `running` are registered from next-state values, so they are coherent with `step_idx`.
- Reset: all outputs are 0, state is IDLE, `tick`=0.

## Timing
- All outputs are registered on `posedge hz2m`. There are no combinational paths from input to output.
- `run` rise at edge E: `running`=1, `step_idx`=0, `beat`=1 after E.
  - `play_smpl` reflects step 0 after edge E+1, which is one cycle of latency.
- A step lasts exactly `tempo_lim`+1 ticks when the limit is held constant.
- `raw` reaches `play_smpl` with one-cycle latency in every state.
- `run` fall at edge E: after E, `running`=0, `step_onehot`=0, `step_idx`=0, `beat`=0, `play_smpl`=`raw`.
- Asynchronous `reset` mid-step clears everything immediately. The next start is always step 0, `tick` 0.

## Configuration
- `STEP_SCHED_SWING_EN` defined:
  - The `swing` port exists.
  - Odd steps (1, 3, 5, 7) use `period = tempo_lim + swing`, computed in CW+1 bits. The compare widens `tick` to CW+1 bits.
  - Even steps use `tempo_lim`.
  - The `gate_lim` rule is unchanged.
- Not defined:
  - No `swing` port.
  - All steps use `tempo_lim`.
  - No extra adder.

## Test plan
- Reset with `run`=1 held. Release reset: first edge gives `running`=1, `step_idx`=0, `beat`=1, `step_onehot`=8'h01. All outputs are 0 while reset is high.
- `tempo_lim`=3, `gate_lim`=2, `pattern`=32'h8000_0001, `raw`=0:
  - `beat` pulses every 4 cycles.
  - `play_smpl`=4'b0001 for 2 cycles at step 0, then 0.
  - `play_smpl`=4'b1000 for 2 cycles at step 7.
  - `step_idx` wraps 7→0.
- `raw`=4'b0100 in IDLE and in RUN with an empty pattern: `play_smpl`=4'b0100 one cycle later in both states.
- Drop `run` at `step_idx`=5, `tick`=2, then raise it again 3 cycles later: the restart is step 0 with `beat`=1 and no stale triggers.
- Tempo change: `tempo_lim` goes 9→2 while `tick`=6. The step ends on the next edge; following steps last 3 cycles.
- With `STEP_SCHED_SWING_EN`, `tempo_lim`=3, `swing`=2: step durations alternate 4, 6, 4, 6 cycles, and `beat` spacing matches.
